regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file for the RV32I core: two combinational read ports and two synchronous write ports. Port A carries single-cycle ALU writeback; port B carries late writeback (loads, multi-cycle ops). A per-register pending scoreboard marks registers reserved for port B and drives a hazard output to the issue stage. Optional read-during-write bypass. Register 0 is hardwired to zero.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >= 2)
AW, $clog2(NREG), address width (derived; not overridden)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = writes visible the cycle after the edge

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rs1_addr  in  AW  read port 1 address
rs2_addr  in  AW  read port 2 address
rs1_data  out  XLEN  read port 1 data (combinational)
rs2_data  out  XLEN  read port 2 data (combinational)
wa_en  in  1  port A write enable
wa_addr  in  AW  port A write address
wa_data  in  XLEN  port A write data
wb_en  in  1  port B write enable; also releases the reservation on wb_addr
wb_addr  in  AW  port B write address
wb_data  in  XLEN  port B write data
rsv_en  in  1  reserve rsv_addr for a future port B writeback
rsv_addr  in  AW  register to reserve
rs1_busy  out  1  rs1_addr is pending (combinational)
rs2_busy  out  1  rs2_addr is pending (combinational)
hazard  out  1  rs1_busy | rs2_busy
pend_cnt  out  AW+1  number of registers currently pending (registered)
rsv_dup  out  1  one-cycle registered pulse: rsv_en hit an already-pending register

Behaviour:
- Reset (rst_n low, asynchronous): all NREG registers = 0, all pending bits = 0, pend_cnt = 0, rsv_dup = 0. Reads return 0 and busy = 0 while in reset. Reset mid-operation discards all reservations and data.
- Writes: on rising clk, wa_en writes wa_data to wa_addr; wb_en writes wb_data to wb_addr. Both ports write the same non-zero address in one cycle: port A wins (younger instruction).
- Address 0: writes ignored, reservations ignored, reads return 0, never busy, never counted.
- Reads, BYPASS=0: stored contents only.
- Reads, BYPASS=1: priority per read port is (addr==0 -> 0), matching wa_en, matching wb_en, stored value.
- Scoreboard: pending[r] is set at the clock edge by rsv_en with rsv_addr=r, and cleared by wb_en with wb_addr=r. Set and clear of the same register in the same cycle: set wins, giving a new reservation. Port A writes do not touch pending bits.
- wb_en to a non-pending register: data is written; pending is unchanged.
- rsN_busy = pending[rsN_addr] and not (BYPASS and wb_en and wb_addr==rsN_addr). With BYPASS=0, a same-cycle release still reports busy.
- rsv_dup: asserted in the cycle after rsv_en targets a register that was already pending and was not released in that same cycle. The pending bit stays 1 and pend_cnt does not change.
- pend_cnt: updated at each edge by +1 (new set), -1 (clear), or 0 (both on different registers, or neither). It never exceeds NREG-1. Equals popcount(pending) at all times.

Decomposition:
- Package regfile_pkg: XLEN, NREG, AW defaults and constant ZERO_REG = 0.
- Sub-module regfile_scoreboard: pending bit vector, pend_cnt, rsv_dup, and the busy lookup.
- Storage array and bypass muxing stay in regfile_sb.

Test Plan:
- Reset then read: reset, read x5 and x0 -> rs1_data = rs2_data = 0, pend_cnt = 0, hazard = 0.
- Write/read and x0: wa writes 0xDEADBEEF to x5, then reads x5 -> 0xDEADBEEF next cycle. With BYPASS=1, a same-cycle read also returns 0xDEADBEEF. wa write 0x1234 to x0 -> x0 still reads 0.
- Port conflict: wa (x7, 0xA) and wb (x7, 0xB) in the same cycle -> x7 = 0xA. Same-cycle bypass read of x7 -> 0xA.
- Reserve/release: rsv x9 -> rs1_busy = 1 while rs1_addr = 9, pend_cnt = 1. Next, wb x9 = 0x55 -> busy drops in that cycle (BYPASS=1) with rs1_data = 0x55, and pend_cnt = 0 after the edge.
- Simultaneous set/clear and duplicate: with x3 pending, issue rsv x3 and wb x3 in the same cycle -> x3 stays pending, pend_cnt unchanged, rsv_dup = 0. Then rsv x3 alone -> rsv_dup = 1 for exactly one cycle. rsv x0 -> no effect.
- Async reset mid-op: x4 and x6 pending, x4 = 0x77; drop rst_n between edges -> outputs clear immediately, pend_cnt = 0, x4 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the RV32I integer register file and its pending-writeback scoreboard.
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = $clog2(DEF_NREG);
    localparam int ZERO_REG = 0;

    // One-hot mask of width n with bit idx set, or all zero when en is low.
    function automatic logic [DEF_NREG-1:0] onehot_mask(input logic en, input int unsigned idx);
        logic [DEF_NREG-1:0] m;
        m = {DEF_NREG{1'b0}};
        if (en) begin
            m[idx] = 1'b1;
        end else begin
            m = {DEF_NREG{1'b0}};
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback scoreboard: one reservation bit per register, a live count,
// a duplicate-reservation pulse and the busy lookup for both read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int AW     = $clog2(NREG),
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rsv_en,
    input  logic [AW-1:0] rsv_addr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic [AW:0]   pend_cnt,
    output logic          rsv_dup
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};

    logic [NREG-1:0] pending_r;
    logic [NREG-1:0] pend_nxt_s;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;
    logic [AW:0]     pend_cnt_r;
    logic            rsv_dup_r;
    logic            set_vld_s;
    logic            clr_vld_s;
    logic            same_reg_s;
    logic            inc_s;
    logic            dec_s;
    logic            dup_nxt_s;

    assign set_vld_s  = rsv_en && (rsv_addr != ZERO_ADDR);
    assign clr_vld_s  = wb_en && (wb_addr != ZERO_ADDR);
    assign same_reg_s = (rsv_addr == wb_addr);

    // Next pending vector and count/duplicate decisions; a set beats a same-cycle clear.
    always_comb begin
        set_mask_s = {NREG{1'b0}};
        clr_mask_s = {NREG{1'b0}};
        if (set_vld_s) begin
            set_mask_s[rsv_addr] = 1'b1;
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        if (clr_vld_s) begin
            clr_mask_s[wb_addr] = 1'b1;
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        pend_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
        inc_s      = set_vld_s && !pending_r[rsv_addr];
        dec_s      = clr_vld_s && pending_r[wb_addr] && !(set_vld_s && same_reg_s);
        dup_nxt_s  = set_vld_s && pending_r[rsv_addr] && !(clr_vld_s && same_reg_s);
    end

    // Pending bits, live count and duplicate pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= {NREG{1'b0}};
            pend_cnt_r <= {(AW+1){1'b0}};
            rsv_dup_r  <= 1'b0;
        end else begin
            pending_r <= pend_nxt_s;
            rsv_dup_r <= dup_nxt_s;
            case ({inc_s, dec_s})
                2'b10:   pend_cnt_r <= pend_cnt_r + CNT_ONE;
                2'b01:   pend_cnt_r <= pend_cnt_r - CNT_ONE;
                default: pend_cnt_r <= pend_cnt_r;
            endcase
        end
    end

    // A release in flight on port B already covers the reader when bypassing.
    assign rs1_busy = pending_r[rs1_addr] && !(BYPASS && wb_en && (wb_addr == rs1_addr));
    assign rs2_busy = pending_r[rs2_addr] && !(BYPASS && wb_en && (wb_addr == rs2_addr));
    assign pend_cnt = pend_cnt_r;
    assign rsv_dup  = rsv_dup_r;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with two read ports, ALU (A) and late (B) write ports,
// optional read-during-write bypass and a pending-writeback scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREG   = DEF_NREG,
    parameter int AW     = $clog2(NREG),
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            hazard,
    output logic [AW:0]     pend_cnt,
    output logic            rsv_dup
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] regs_r [NREG];
    logic [XLEN-1:0] rs1_data_s;
    logic [XLEN-1:0] rs2_data_s;

    // Read mux: x0, then port A, then port B, then stored contents.
    function automatic logic [XLEN-1:0] read_mux(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] stored,
        input logic            a_en,
        input logic [AW-1:0]   a_addr,
        input logic [XLEN-1:0] a_data,
        input logic            b_en,
        input logic [AW-1:0]   b_addr,
        input logic [XLEN-1:0] b_data
    );
        logic [XLEN-1:0] r;
        if (addr == ZERO_ADDR) begin
            r = {XLEN{1'b0}};
        end else if (BYPASS && a_en && (a_addr == addr)) begin
            r = a_data;
        end else if (BYPASS && b_en && (b_addr == addr)) begin
            r = b_data;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Storage; port A wins a same-address collision as the younger instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            regs_r[0] <= {XLEN{1'b0}};
            for (int i = 1; i < NREG; i++) begin
                if (wa_en && (wa_addr == AW'(i))) begin
                    regs_r[i] <= wa_data;
                end else if (wb_en && (wb_addr == AW'(i))) begin
                    regs_r[i] <= wb_data;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Read ports are forced to zero while reset is held so bypass cannot leak data.
    always_comb begin
        rs1_data_s = {XLEN{1'b0}};
        rs2_data_s = {XLEN{1'b0}};
        if (rst_n) begin
            rs1_data_s = read_mux(rs1_addr, regs_r[rs1_addr], wa_en, wa_addr, wa_data,
                                  wb_en, wb_addr, wb_data);
            rs2_data_s = read_mux(rs2_addr, regs_r[rs2_addr], wa_en, wa_addr, wa_data,
                                  wb_en, wb_addr, wb_data);
        end else begin
            rs1_data_s = {XLEN{1'b0}};
            rs2_data_s = {XLEN{1'b0}};
        end
    end

    assign rs1_data = rs1_data_s;
    assign rs2_data = rs2_data_s;

    regfile_scoreboard #(
        .NREG   (NREG),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .pend_cnt (pend_cnt),
        .rsv_dup  (rsv_dup)
    );

    assign hazard = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected values, a negedge monitor checks them.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam int S_RS1D = 0;
    localparam int S_RS2D = 1;
    localparam int S_B1   = 2;
    localparam int S_B2   = 3;
    localparam int S_HAZ  = 4;
    localparam int S_CNT  = 5;
    localparam int S_DUP  = 6;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            wa_en, wb_en, rsv_en;
    logic [AW-1:0]   wa_addr, wb_addr, rsv_addr;
    logic [XLEN-1:0] wa_data, wb_data;
    logic            rs1_busy, rs2_busy, hazard, rsv_dup;
    logic [AW:0]     pend_cnt;

    string       name_q [$];
    int          sel_q  [$];
    logic [31:0] exp_q  [$];
    int          pass_cnt;
    int          total_cnt;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .hazard(hazard),
        .pend_cnt(pend_cnt), .rsv_dup(rsv_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_RS1D:  return rs1_data;
            S_RS2D:  return rs2_data;
            S_B1:    return {31'd0, rs1_busy};
            S_B2:    return {31'd0, rs2_busy};
            S_HAZ:   return {31'd0, hazard};
            S_CNT:   return {26'd0, pend_cnt};
            S_DUP:   return {31'd0, rsv_dup};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Monitor: drain every expectation queued for this cycle, away from the rising edge.
    always @(negedge clk) begin
        while (sel_q.size() > 0) begin
            string       n;
            int          s;
            logic [31:0] e;
            logic [31:0] a;
            n = name_q.pop_front();
            s = sel_q.pop_front();
            e = exp_q.pop_front();
            a = actual(s);
            total_cnt++;
            if (a === e) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got %h expected %h", n, a, e);
            end
        end
    end

    task automatic expect_v(input string n, input int sel, input logic [31:0] v);
        name_q.push_back(n);
        sel_q.push_back(sel);
        exp_q.push_back(v);
    endtask

    // Advance one edge, then clear all request strobes.
    task automatic cyc();
        @(posedge clk);
        #1;
        wa_en  = 1'b0;
        wb_en  = 1'b0;
        rsv_en = 1'b0;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        wa_en = 1'b0; wa_addr = 5'd0; wa_data = 32'd0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        rsv_en = 1'b0; rsv_addr = 5'd0;

        // Reset then read x5 / x0
        cyc();
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        expect_v("rst_rs1", S_RS1D, 32'd0);
        expect_v("rst_rs2", S_RS2D, 32'd0);
        expect_v("rst_cnt", S_CNT, 32'd0);
        expect_v("rst_haz", S_HAZ, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Write x5 with same-cycle bypass, then stored read
        wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEADBEEF;
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        expect_v("byp_wa_rs1", S_RS1D, 32'hDEADBEEF);
        expect_v("byp_wa_rs2", S_RS2D, 32'hDEADBEEF);
        cyc();
        expect_v("stored_x5", S_RS1D, 32'hDEADBEEF);

        // x0 ignores writes, also under bypass
        cyc();
        wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'h1234;
        rs1_addr = 5'd0;
        expect_v("x0_byp", S_RS1D, 32'd0);
        cyc();
        expect_v("x0_stored", S_RS1D, 32'd0);

        // Port conflict on x7: port A wins
        cyc();
        wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'hA;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hB;
        rs1_addr = 5'd7;
        expect_v("conflict_byp", S_RS1D, 32'hA);
        cyc();
        expect_v("conflict_stored", S_RS1D, 32'hA);

        // Reserve x9, then release with wb
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        rs1_addr = 5'd9; rs2_addr = 5'd0;
        expect_v("rsv9_not_yet", S_B1, 32'd0);
        cyc();
        expect_v("rsv9_busy", S_B1, 32'd1);
        expect_v("rsv9_haz", S_HAZ, 32'd1);
        expect_v("rsv9_cnt", S_CNT, 32'd1);
        cyc();
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
        expect_v("rel9_busy", S_B1, 32'd0);
        expect_v("rel9_data", S_RS1D, 32'h55);
        expect_v("rel9_cnt_pre", S_CNT, 32'd1);
        cyc();
        expect_v("rel9_cnt", S_CNT, 32'd0);
        expect_v("rel9_stored", S_RS1D, 32'h55);

        // x3: simultaneous set/clear, then duplicate, then x0 reservation
        rsv_en = 1'b1; rsv_addr = 5'd3;
        cyc();
        expect_v("rsv3_cnt", S_CNT, 32'd1);
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        rs2_addr = 5'd3;
        expect_v("setclr_b2", S_B2, 32'd0);
        cyc();
        expect_v("setclr_b2_after", S_B2, 32'd1);
        expect_v("setclr_cnt", S_CNT, 32'd1);
        expect_v("setclr_dup", S_DUP, 32'd0);
        expect_v("setclr_data", S_RS2D, 32'h33);
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd3;
        cyc();
        expect_v("dup_pulse", S_DUP, 32'd1);
        expect_v("dup_cnt", S_CNT, 32'd1);
        cyc();
        expect_v("dup_one_cycle", S_DUP, 32'd0);
        rsv_en = 1'b1; rsv_addr = 5'd0;
        cyc();
        rs1_addr = 5'd0;
        expect_v("rsv0_cnt", S_CNT, 32'd1);
        expect_v("rsv0_busy", S_B1, 32'd0);
        expect_v("rsv0_dup", S_DUP, 32'd0);

        // Async reset mid-operation with x3, x4, x6 pending
        rsv_en = 1'b1; rsv_addr = 5'd4;
        cyc();
        rsv_en = 1'b1; rsv_addr = 5'd6;
        wa_en = 1'b1; wa_addr = 5'd4; wa_data = 32'h77;
        cyc();
        rs1_addr = 5'd4;
        expect_v("pre_rst_cnt", S_CNT, 32'd3);
        expect_v("pre_rst_data", S_RS1D, 32'h77);
        expect_v("pre_rst_busy", S_B1, 32'd1);
        cyc();
        rst_n = 1'b0;
        expect_v("arst_data", S_RS1D, 32'd0);
        expect_v("arst_busy", S_B1, 32'd0);
        expect_v("arst_haz", S_HAZ, 32'd0);
        expect_v("arst_cnt", S_CNT, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        expect_v("post_rst_x4", S_RS1D, 32'd0);
        expect_v("post_rst_cnt", S_CNT, 32'd0);

        for (int i = 0; i < 20 && sel_q.size() > 0; i++) begin
            cyc();
        end
        cyc();
        if (sel_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending expected 0", sel_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
